av_ram_pipelined: RTL and testbench
===================================

Name: av_ram_pipelined

Overview:
Parametrised Avalon-MM word-addressed RAM slave, the successor to the single-cycle scratch RAM used on the data bus. It adds the following over that block:
- configurable data width and depth
- 1- or 2-cycle pipelined reads with a readdatavalid strobe
- defined read-during-write behaviour
- a hardware zero-fill sequencer that runs after reset or on request, and holds off the bus while it runs

It sits on the shared DBUS behind the peripheral-select decode, like every other slave.

Parameters:
NUM_PERIPH_SEL_BITS, 5, number of top address bits used for slave select
PERIPH_SEL_VAL, 0, select value matched against those top bits
ADDR_W, 30, Avalon word-address width
DATA_W, 32, data width; multiple of 8
DEPTH, 256, number of words; need not be a power of two
READ_LATENCY, 1, cycles from accepted read to valid data; legal values 1 or 2
RDW_NEW, 0, read-during-write to the same word: 0 returns old data, 1 returns new (byte-merged) data

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  asynchronous active-low reset
i_AV_Addr  in  ADDR_W  word address
i_AV_ByteEn  in  DATA_W/8  byte enables
i_AV_Read  in  1  read request
i_AV_Write  in  1  write request
i_AV_WriteData  in  DATA_W  write data
o_AV_ReadData  out  DATA_W  read data; zero when not valid
o_AV_ReadDataValid  out  1  read data valid strobe
o_AV_WaitRequest  out  1  high while the clear sequence is running
i_Clear  in  1  single-cycle pulse that starts a zero-fill
o_InitDone  out  1  high once the memory is cleared and ready

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst_n is asynchronous and active-low.
- Reset values: state=CLEAR, clear counter=0, o_AV_ReadData=0, o_AV_ReadDataValid=0, o_AV_WaitRequest=1, o_InitDone=0, read pipeline flushed. Memory contents are not reset directly; the CLEAR state zeroes them.
- Select and decode:
  - Select when i_AV_Addr[ADDR_W-1 -: NUM_PERIPH_SEL_BITS] == PERIPH_SEL_VAL.
  - Index = i_AV_Addr[$clog2(DEPTH)-1:0].
  - Index >= DEPTH (non-power-of-two DEPTH): write dropped; read still produces valid with data 0.
  - Unselected requests are ignored: no valid, no write.
- FSM:
  - CLEAR: one word per cycle, write 0 to all bytes at counter, counter++. WaitRequest=1. When counter==DEPTH-1 is written, go to READY next cycle. Takes DEPTH cycles total.
  - READY: WaitRequest=0, InitDone=1. An i_Clear pulse moves to CLEAR with counter=0 on the next edge. A bus request in that same cycle is still accepted.
- Accepted request: selected && (Read || Write) && WaitRequest==0. During CLEAR the master holds its request and nothing is accepted.
- Write: each byte lane k is updated only when ByteEn[k]=1. Write and read are both honoured if asserted together.
- Read pipeline:
  - READ_LATENCY=1: data and valid registered on the edge after acceptance.
  - READ_LATENCY=2: one additional output register stage.
  - Fully pipelined: back-to-back reads, one per cycle, with no bubbles.
  - o_AV_ReadData is forced to 0 whenever valid=0.
- Read-during-write, same word, same cycle:
  - RDW_NEW=0 returns the pre-write word.
  - RDW_NEW=1 returns the word with enabled bytes replaced by WriteData.
- Reads in flight when i_Clear arrives still complete with pre-clear data.
- Reset mid-CLEAR or mid-read: pipeline flushed, no valid emitted, clear restarts at 0.
- i_Clear during CLEAR is ignored; the sweep is not restarted.

Decomposition:
- Shared package av_pkg:
  - FSM state enum {ST_CLEAR, ST_READY}
  - localparam helpers for byte-lane count (DATA_W/8) and index width ($clog2(DEPTH))
  - legal READ_LATENCY constants, used by a parameter assertion
- One natural sub-module: av_ram_bytemem. It holds the byte-enabled synchronous memory array plus the RDW mux, with a single write port (bus or clear sequencer, muxed in the parent) and a single read port. The parent keeps the decode, the FSM and the latency pipeline.

Test Plan:
- Reset release, DEPTH=256: WaitRequest=1 for exactly 256 cycles, then 0, InitDone=1. A read of index 0x80 returns 0x00000000.
- Write index 5, data 0xDEADBEEF, ByteEn=4'b0101 over prior 0x11223344: a read returns 0x11AD33EF. ReadDataValid arrives 1 cycle later (LAT=1) or 2 cycles later (LAT=2).
- Four back-to-back reads of indices 0-3 holding 0xA0-0xA3: four consecutive valid cycles with data in order, no gaps. ReadData=0 on the cycles either side.
- Same-cycle write 0xCAFEF00D (ByteEn=4'hF) and read of index 9 holding 0x12345678: RDW_NEW=0 returns 0x12345678; RDW_NEW=1 returns 0xCAFEF00D.
- i_Clear pulse while index 7 = 0x55AA55AA: WaitRequest=1 for DEPTH cycles, then index 7 reads 0. Assert i_Rst_n=0 at sweep cycle 100: outputs return to reset values and the sweep restarts from 0, taking the full DEPTH cycles.
- Unselected address (top bits ≠ PERIPH_SEL_VAL) read or write: no valid, memory unchanged. DEPTH=200, read of index 250: valid with data 0, and a write there is dropped.

Source files
------------

// File: rtl/av_ram_pipelined_pkg.sv
// Shared definitions for the pipelined Avalon-MM RAM slave: FSM states,
// legal read latencies and the helpers that size byte lanes and indices.
package av_pkg;

    // Zero-fill sweep in progress, or serving the bus
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } av_state_e;

    // The only read latencies the output pipeline knows how to build
    localparam int LAT_ONE = 1;
    localparam int LAT_TWO = 2;

    // Number of 8-bit lanes in a data word
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a word index; a single-word memory still needs one bit
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // True for a read latency the parent can implement
    function automatic bit latency_legal(input int lat);
        return (lat == LAT_ONE) || (lat == LAT_TWO);
    endfunction

endpackage

// File: rtl/av_ram_bytemem.sv
// Byte-enabled synchronous word memory with one write port and one
// registered read port. When a read and a write hit the same word in the
// same cycle, RDW_NEW selects between the old word and the byte-merged one.
module av_ram_bytemem
    import av_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 256,
    parameter  int RDW_NEW = 0,
    localparam int LANES   = byte_lanes(DATA_W),
    localparam int IDX_W   = index_width(DEPTH)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LANES-1:0]  wr_byte_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_q;

    // Update only the enabled byte lanes of the addressed word
    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_byte_en[k]) begin
                    mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Pick the word the read port returns, forwarding written bytes when new-data RDW is chosen
    always_comb begin
        rd_word = mem[rd_idx];
        if ((RDW_NEW != 0) && wr_en && rd_en && (wr_idx == rd_idx)) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_byte_en[k]) begin
                    rd_word[k*8 +: 8] = wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Read register: captures the selected word on the edge that accepts the read
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= rd_word;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/av_ram_pipelined.sv
// Avalon-MM word-addressed RAM slave on the shared DBUS. Decodes its
// peripheral select, runs a zero-fill sweep after reset or on i_Clear
// (holding the bus off with waitrequest), and returns read data through a
// 1- or 2-stage pipeline with a readdatavalid strobe.
module av_ram_pipelined
    import av_pkg::*;
#(
    parameter int NUM_PERIPH_SEL_BITS = 5,
    parameter int PERIPH_SEL_VAL      = 0,
    parameter int ADDR_W              = 30,
    parameter int DATA_W              = 32,
    parameter int DEPTH               = 256,
    parameter int READ_LATENCY        = 1,
    parameter int RDW_NEW             = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [ADDR_W-1:0]     i_AV_Addr,
    input  logic [DATA_W/8-1:0]   i_AV_ByteEn,
    input  logic                  i_AV_Read,
    input  logic                  i_AV_Write,
    input  logic [DATA_W-1:0]     i_AV_WriteData,
    output logic [DATA_W-1:0]     o_AV_ReadData,
    output logic                  o_AV_ReadDataValid,
    output logic                  o_AV_WaitRequest,
    input  logic                  i_Clear,
    output logic                  o_InitDone
);

    localparam int LANES  = byte_lanes(DATA_W);
    localparam int IDX_W  = index_width(DEPTH);
    localparam int IDX_W1 = IDX_W + 1;
    localparam logic [NUM_PERIPH_SEL_BITS-1:0] SEL_V    = NUM_PERIPH_SEL_BITS'(PERIPH_SEL_VAL);
    localparam logic [IDX_W1-1:0]              DEPTH_V  = IDX_W1'(DEPTH);
    localparam logic [IDX_W-1:0]               LAST_IDX = IDX_W'(DEPTH - 1);

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("av_ram_pipelined: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("av_ram_pipelined: DATA_W must be a multiple of 8");
    end

    av_state_e         state;
    logic [IDX_W-1:0]  clr_cnt;
    logic              wait_q;
    logic              done_q;

    logic              sel;
    logic [IDX_W-1:0]  bus_idx;
    logic              in_range;
    logic              accept_rd;
    logic              accept_wr;

    logic              mem_wr_en;
    logic [IDX_W-1:0]  mem_wr_idx;
    logic [LANES-1:0]  mem_wr_be;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;

    logic              s1_valid;
    logic              s1_zero;
    logic [DATA_W-1:0] s1_data;

    // Only the select field and the low index bits are decoded; the rest of the address is don't-care
    logic              unused_addr;
    assign unused_addr = ^i_AV_Addr;

    // Decode select, index range and whether the bus request is taken this cycle
    always_comb begin
        sel       = (i_AV_Addr[ADDR_W-1 -: NUM_PERIPH_SEL_BITS] == SEL_V);
        bus_idx   = i_AV_Addr[IDX_W-1:0];
        in_range  = ({1'b0, bus_idx} < DEPTH_V);
        accept_rd = sel && i_AV_Read  && !wait_q;
        accept_wr = sel && i_AV_Write && !wait_q;
    end

    // Steer the single write port to the clear sweep or the bus, and gate reads to real words
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_idx  = bus_idx;
        mem_wr_be   = i_AV_ByteEn;
        mem_wr_data = i_AV_WriteData;
        mem_rd_en   = accept_rd && in_range;
        if (state == ST_CLEAR) begin
            mem_wr_en   = 1'b1;
            mem_wr_idx  = clr_cnt;
            mem_wr_be   = '1;
            mem_wr_data = '0;
        end else begin
            mem_wr_en   = accept_wr && in_range;
        end
    end

    // Sweep one word per cycle while clearing, then serve the bus until a clear pulse
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            wait_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state  <= ST_READY;
                        wait_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (i_Clear) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        wait_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    wait_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    av_ram_bytemem #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RDW_NEW (RDW_NEW)
    ) u_mem (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .wr_en      (mem_wr_en),
        .wr_idx     (mem_wr_idx),
        .wr_byte_en (mem_wr_be),
        .wr_data    (mem_wr_data),
        .rd_en      (mem_rd_en),
        .rd_idx     (bus_idx),
        .rd_data    (mem_rd_data)
    );

    // First pipeline stage tracks which accepted reads are valid and which fall outside the array
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            s1_valid <= accept_rd;
            s1_zero  <= accept_rd && !in_range;
        end
    end

    // Out-of-range reads and idle cycles present zero data
    always_comb begin
        s1_data = '0;
        if (s1_valid && !s1_zero) begin
            s1_data = mem_rd_data;
        end
    end

    if (READ_LATENCY == LAT_TWO) begin : g_lat2
        logic              s2_valid;
        logic [DATA_W-1:0] s2_data;

        // Extra output register stage for the two-cycle latency build
        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
            end
        end

        assign o_AV_ReadDataValid = s2_valid;
        assign o_AV_ReadData      = s2_data;
    end else begin : g_lat1
        assign o_AV_ReadDataValid = s1_valid;
        assign o_AV_ReadData      = s1_data;
    end

    assign o_AV_WaitRequest = wait_q;
    assign o_InitDone       = done_q;

endmodule

// File: tb/tb_av_ram_pipelined.sv
// Directed bench for av_ram_pipelined. Two instances share one stimulus
// stream: u_dut0 uses the defaults (256 words, latency 1, old-data RDW) and
// u_dut1 uses 200 words, latency 2 and new-data RDW.
module tb_av_ram_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        clr;

    logic [31:0] rdata0, rdata1;
    logic        rv0, rv1;
    logic        wait0, wait1;
    logic        done0, done1;

    int vectors     = 0;
    int miscompares = 0;
    int c0, c1;

    always #5 clk = ~clk;

    av_ram_pipelined u_dut0 (
        .i_Clk              (clk),
        .i_Rst_n            (rst_n),
        .i_AV_Addr          (addr),
        .i_AV_ByteEn        (be),
        .i_AV_Read          (rd),
        .i_AV_Write         (wr),
        .i_AV_WriteData     (wdata),
        .o_AV_ReadData      (rdata0),
        .o_AV_ReadDataValid (rv0),
        .o_AV_WaitRequest   (wait0),
        .i_Clear            (clr),
        .o_InitDone         (done0)
    );

    av_ram_pipelined #(
        .DEPTH        (200),
        .READ_LATENCY (2),
        .RDW_NEW      (1)
    ) u_dut1 (
        .i_Clk              (clk),
        .i_Rst_n            (rst_n),
        .i_AV_Addr          (addr),
        .i_AV_ByteEn        (be),
        .i_AV_Read          (rd),
        .i_AV_Write         (wr),
        .i_AV_WriteData     (wdata),
        .o_AV_ReadData      (rdata1),
        .o_AV_ReadDataValid (rv1),
        .o_AV_WaitRequest   (wait1),
        .i_Clear            (clr),
        .o_InitDone         (done1)
    );

    // Advance one clock and land just after the edge so outputs are settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [29:0] a, input logic [3:0] b, input logic r,
                                 input logic w, input logic [31:0] d, input logic c);
        addr  = a;
        be    = b;
        rd    = r;
        wr    = w;
        wdata = d;
        clr   = c;
    endtask

    task automatic idle();
        applyStimulus(30'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic writeWord(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d);
        applyStimulus(a, b, 1'b0, 1'b1, d, 1'b0);
        tick();
        idle();
    endtask

    // One read; dut0 answers on the first edge, dut1 on the second
    task automatic readWord(input string tag, input logic [29:0] a,
                            input logic [31:0] exp0, input logic [31:0] exp1);
        applyStimulus(a, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        checkOutput({tag, "/d0_valid"}, {31'b0, rv0}, 32'd1);
        checkOutput({tag, "/d0_data"}, rdata0, exp0);
        checkOutput({tag, "/d1_early"}, {31'b0, rv1}, 32'd0);
        tick();
        checkOutput({tag, "/d0_after"}, {31'b0, rv0}, 32'd0);
        checkOutput({tag, "/d0_zero"}, rdata0, 32'h0);
        checkOutput({tag, "/d1_valid"}, {31'b0, rv1}, 32'd1);
        checkOutput({tag, "/d1_data"}, rdata1, exp1);
    endtask

    // Count cycles with waitrequest high on each instance, optionally pulsing clear mid-sweep
    task automatic countWait(input int clrAt, output int n0, output int n1);
        int guard;
        n0 = 0;
        n1 = 0;
        guard = 0;
        while ((wait0 || wait1) && guard < 2000) begin
            n0 += int'(wait0);
            n1 += int'(wait1);
            clr = (clrAt >= 0) && (n0 == clrAt);
            guard++;
            tick();
        end
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] e0d, e1d;
        logic        e0v, e1v;

        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        $display("[TB] reset values");
        checkOutput("rst_wait0", {31'b0, wait0}, 32'd1);
        checkOutput("rst_done0", {31'b0, done0}, 32'd0);
        checkOutput("rst_valid0", {31'b0, rv0}, 32'd0);
        checkOutput("rst_data0", rdata0, 32'h0);
        checkOutput("rst_wait1", {31'b0, wait1}, 32'd1);
        checkOutput("rst_done1", {31'b0, done1}, 32'd0);
        checkOutput("rst_valid1", {31'b0, rv1}, 32'd0);

        $display("[TB] initial zero-fill");
        rst_n = 1'b1;
        countWait(-1, c0, c1);
        checkOutput("init_wait_cycles0", c0, 32'd256);
        checkOutput("init_wait_cycles1", c1, 32'd200);
        checkOutput("init_done0", {31'b0, done0}, 32'd1);
        checkOutput("init_done1", {31'b0, done1}, 32'd1);
        readWord("rd_0x80", 30'h80, 32'h0, 32'h0);

        $display("[TB] byte enables");
        writeWord(30'd5, 4'hF, 32'h1122_3344);
        writeWord(30'd5, 4'b0101, 32'hDEAD_BEEF);
        readWord("byteen", 30'd5, 32'h11AD_33EF, 32'h11AD_33EF);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 4; i++) writeWord(30'(i), 4'hF, 32'hA0 + 32'(i));
        checkOutput("b2b_pre_data0", rdata0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(30'(i), 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            else       idle();
            tick();
            e0v = (i < 4);
            e0d = e0v ? 32'hA0 + 32'(i) : 32'h0;
            e1v = (i >= 1) && (i <= 4);
            e1d = e1v ? 32'hA0 + 32'(i - 1) : 32'h0;
            checkOutput($sformatf("b2b%0d_v0", i), {31'b0, rv0}, {31'b0, e0v});
            checkOutput($sformatf("b2b%0d_d0", i), rdata0, e0d);
            checkOutput($sformatf("b2b%0d_v1", i), {31'b0, rv1}, {31'b0, e1v});
            checkOutput($sformatf("b2b%0d_d1", i), rdata1, e1d);
        end
        idle();

        $display("[TB] read during write");
        writeWord(30'd9, 4'hF, 32'h1234_5678);
        applyStimulus(30'd9, 4'hF, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        tick();
        idle();
        checkOutput("rdw_v0", {31'b0, rv0}, 32'd1);
        checkOutput("rdw_old_d0", rdata0, 32'h1234_5678);
        tick();
        checkOutput("rdw_v1", {31'b0, rv1}, 32'd1);
        checkOutput("rdw_new_d1", rdata1, 32'hCAFE_F00D);
        readWord("rdw_after", 30'd9, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("[TB] unselected accesses");
        applyStimulus(30'h0200_0005, 4'hF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        applyStimulus(30'h0200_0005, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        checkOutput("unsel_v0", {31'b0, rv0}, 32'd0);
        tick();
        checkOutput("unsel_v1", {31'b0, rv1}, 32'd0);
        readWord("unsel_mem", 30'd5, 32'h11AD_33EF, 32'h11AD_33EF);

        $display("[TB] index beyond depth");
        writeWord(30'd250, 4'hF, 32'h7777_7777);
        readWord("oob250", 30'd250, 32'h7777_7777, 32'h0);

        $display("[TB] clear request");
        writeWord(30'd7, 4'hF, 32'h55AA_55AA);
        readWord("pre_clr_idx7", 30'd7, 32'h55AA_55AA, 32'h55AA_55AA);
        applyStimulus(30'd5, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
        checkOutput("clr_wait0", {31'b0, wait0}, 32'd1);
        checkOutput("clr_done0", {31'b0, done0}, 32'd0);
        checkOutput("clr_inflight_v0", {31'b0, rv0}, 32'd1);
        checkOutput("clr_inflight_d0", rdata0, 32'h11AD_33EF);
        tick();
        checkOutput("clr_inflight_v1", {31'b0, rv1}, 32'd1);
        checkOutput("clr_inflight_d1", rdata1, 32'h11AD_33EF);
        countWait(-1, c0, c1);
        checkOutput("clr_wait_cycles0", c0 + 1, 32'd256);
        checkOutput("clr_wait_cycles1", c1 + 1, 32'd200);
        readWord("clr_idx7", 30'd7, 32'h0, 32'h0);

        $display("[TB] reset in the middle of a sweep");
        applyStimulus(30'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wait0", {31'b0, wait0}, 32'd1);
        checkOutput("midrst_done0", {31'b0, done0}, 32'd0);
        checkOutput("midrst_valid0", {31'b0, rv0}, 32'd0);
        checkOutput("midrst_data0", rdata0, 32'h0);
        checkOutput("midrst_wait1", {31'b0, wait1}, 32'd1);
        checkOutput("midrst_valid1", {31'b0, rv1}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        countWait(50, c0, c1);
        checkOutput("restart_wait_cycles0", c0, 32'd256);
        checkOutput("restart_wait_cycles1", c1, 32'd200);
        checkOutput("restart_done0", {31'b0, done0}, 32'd1);
        readWord("restart_idx5", 30'd5, 32'h0, 32'h0);
        readWord("restart_idx250", 30'd250, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
